sys_seq_ctrl: RTL and testbench
===============================

Name: sys_seq_ctrl

Overview:
Parametrised successor to the single-channel ALU/UART controller. It round-robins over up to NUM_CH operand channels and issues one ALU operation per enabled channel per sweep. ALU results (2*WIDTH bits) are buffered in an internal FIFO and streamed out as WIDTH-bit bytes over a valid/ready transmit interface. It sits between the register file / ALU and the UART transmitter, in the main CLK domain.

Parameters:
WIDTH, 8, operand and TX byte width
ALU_FUN_WD, 4, ALU function code width
NUM_CH, 4, number of operand channels (2..16)
FIFO_DEPTH, 4, result FIFO depth in entries (power of 2)
TIMEOUT, 15, WAIT-state cycles allowed before an ALU op is abandoned

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous reset, active-high
START  in  1  one-cycle pulse that begins one sweep; ignored unless IDLE
CH_EN  in  NUM_CH  channel enable mask, sampled when START is accepted
CH_FUN  in  NUM_CH*ALU_FUN_WD  per-channel ALU function; channel i uses bits [i*ALU_FUN_WD +: ALU_FUN_WD]
ALU_Enable  out  1  one-cycle op request
ALU_FUN  out  ALU_FUN_WD  function code for the current op
ALU_SEL  out  $clog2(NUM_CH)  operand-mux channel select
ALU_OUT  in  2*WIDTH  ALU result
ALU_VLD  in  1  result valid
TX_DATA  out  WIDTH  byte to transmitter
TX_VALID  out  1  byte valid
TX_READY  in  1  transmitter accepts byte
SEQ_BUSY  out  1  high whenever state is not IDLE
DONE  out  1  one-cycle pulse at sweep end
TO_ERR  out  1  sticky timeout flag; set by SEQ_TIMEOUT_EN logic, cleared on accepted START
FIFO_CNT  out  $clog2(FIFO_DEPTH)+1  result FIFO occupancy

Behaviour:
- Reset: sync, active-high. Any state, including mid-op, goes to IDLE. FIFO is emptied and the byte pointer cleared. All outputs are 0.
- FSM states: IDLE, ISSUE, WAIT, NEXT.
- IDLE: START=1 latches CH_EN into the mask register. If mask is nonzero: ptr = lowest set bit, go to ISSUE, clear TO_ERR. If mask is zero: DONE pulses next cycle, stay IDLE.
- ISSUE: if FIFO_CNT < FIFO_DEPTH, register ALU_Enable=1, ALU_FUN=CH_FUN[ptr], ALU_SEL=ptr, go to WAIT. Otherwise stall in ISSUE. Results are never dropped.
- Latency: START high in cycle 0 -> ALU_Enable high in cycle 2, for exactly 1 cycle.
- ALU_FUN and ALU_SEL hold their values until the next issue.
- WAIT: ALU_VLD is accepted only in WAIT while ALU_Enable=0; it is ignored at all other times. On accept, push ALU_OUT into the FIFO and go to NEXT.
- NEXT: ptr moves to the next set mask bit above ptr. If one exists, go to ISSUE. If none (wrap-around), pulse DONE and go to IDLE.
- FIFO overflow is impossible: one op is outstanding at most, and ISSUE checks fullness first.
- TX side runs independently of the FSM. When the FIFO is non-empty, TX_VALID=1 with TX_DATA = low byte of the head entry.
- TX handshake: a byte is transferred in any cycle with TX_VALID && TX_READY. After the low byte, the high byte is presented. The entry pops when the high byte is accepted.
- TX_VALID stays high while data remains. TX_DATA is stable while TX_VALID && !TX_READY.
- Simultaneous push (WAIT accept) and pop (high byte accepted) in one cycle: FIFO_CNT is unchanged, and both operations take effect.
- Back-to-back entries stream with no bubble.
- START while SEQ_BUSY=1 is ignored. CH_EN and CH_FUN changes mid-sweep do not affect the latched mask, but CH_FUN is read live at ISSUE.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: a counter runs in WAIT starting the cycle after ALU_Enable. If it reaches TIMEOUT with no ALU_VLD, TO_ERR is set (sticky), nothing is pushed, and the FSM goes to NEXT.
- Undefined: WAIT waits indefinitely, and TO_ERR is tied to 0.

Decomposition:
- Package sys_seq_pkg holds:
  - FSM state enum (IDLE, ISSUE, WAIT, NEXT)
  - byte-select constants (BYTE_LO = 0, BYTE_HI = 1)
  - a function that finds the next set bit at or above an index
- Sub-module sys_res_fifo: synchronous FIFO, 2*WIDTH wide, FIFO_DEPTH deep, with push/pop/full/empty/count. The FSM and TX byte serializer stay in the top block.

Test Plan:
- Single sweep: CH_EN=4'b1010, CH_FUN ch1=4'h0, ch3=4'h2, ALU returns 16'h1234 then 16'hABCD with TX_READY=1 -> ALU_SEL 1 then 3; TX bytes 34,12,CD,AB; DONE pulses once; FIFO_CNT ends at 0.
- Backpressure: TX_READY=0, CH_EN=4'hF, 3 sweeps -> ISSUE stalls at FIFO_CNT=4 with no ALU_Enable; on TX_READY=1 the remaining ops issue and all 12 results (24 bytes) arrive in order.
- Empty mask: START with CH_EN=0 -> no ALU_Enable; DONE high in cycle 1; SEQ_BUSY stays 0.
- Timeout (SEQ_TIMEOUT_EN): CH_EN=4'b0011, ALU_VLD withheld on ch0 -> TO_ERR=1 after 15 WAIT cycles; ch1 still issues; one FIFO entry; next START clears TO_ERR.
- Reset mid-op: RST=1 during WAIT with FIFO_CNT=2 and TX_VALID=1 -> next cycle state IDLE, FIFO_CNT=0, TX_VALID=0, ALU_Enable=0.
- Push/pop same cycle: ALU_VLD accepted in the cycle the high byte of the head entry is accepted -> FIFO_CNT unchanged and the data order is preserved.

Source files
------------

// File: rtl/sys_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_seq_pkg
// Description : Shared types and helpers for the sys_seq_ctrl sequencer.
//               Holds the FSM state encoding, the TX byte-select constants,
//               and a function that finds the next set bit in a channel mask.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_seq_pkg;

    // Sequencer FSM states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_NEXT  = 2'd3
    } seq_state_t;

    // Which half of a FIFO entry the TX side is presenting
    localparam logic BYTE_LO = 1'b0;
    localparam logic BYTE_HI = 1'b1;

    // Masks are widened to this many bits before searching
    localparam int MAX_CH = 16;

    // Returned by find_next_set when no set bit exists at or above the index
    localparam logic [4:0] NO_SET_BIT = 5'd16;

    // Lowest set bit of mask at index >= from, or NO_SET_BIT when none
    function automatic logic [4:0] find_next_set(input logic [MAX_CH-1:0] mask,
                                                 input logic [4:0]        from);
        logic [4:0] res;
        res = NO_SET_BIT;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) begin
                res = 5'(i);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sys_seq_ctrl_if
// Description : Bundles the sequencer's control, ALU and TX-stream signals.
//               master = the sequencer, slave = its environment
//               (register file / ALU / UART transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
interface sys_seq_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ALU_FUN_WD = 4,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int SEL_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                         START;
    logic [NUM_CH-1:0]            CH_EN;
    logic [NUM_CH*ALU_FUN_WD-1:0] CH_FUN;
    logic                         ALU_Enable;
    logic [ALU_FUN_WD-1:0]        ALU_FUN;
    logic [SEL_W-1:0]             ALU_SEL;
    logic [2*WIDTH-1:0]           ALU_OUT;
    logic                         ALU_VLD;
    logic [WIDTH-1:0]             TX_DATA;
    logic                         TX_VALID;
    logic                         TX_READY;
    logic                         SEQ_BUSY;
    logic                         DONE;
    logic                         TO_ERR;
    logic [CNT_W-1:0]             FIFO_CNT;

    modport master (
        input  START, CH_EN, CH_FUN, ALU_OUT, ALU_VLD, TX_READY,
        output ALU_Enable, ALU_FUN, ALU_SEL, TX_DATA, TX_VALID,
               SEQ_BUSY, DONE, TO_ERR, FIFO_CNT
    );

    modport slave (
        output START, CH_EN, CH_FUN, ALU_OUT, ALU_VLD, TX_READY,
        input  ALU_Enable, ALU_FUN, ALU_SEL, TX_DATA, TX_VALID,
               SEQ_BUSY, DONE, TO_ERR, FIFO_CNT
    );

endinterface
`default_nettype wire

// File: rtl/sys_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sys_res_fifo
// Description : Synchronous result FIFO with occupancy count. A push while
//               full is accepted only if a pop happens in the same cycle.
//               DEPTH must be a power of two (>= 2) so pointers wrap freely.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_res_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [DATA_W-1:0]        i_data,
    input  wire logic                     i_pop,
    output logic      [DATA_W-1:0]        o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int c_addr_w = $clog2(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_do_pop;
    logic                w_do_push;

    assign o_full    = (r_count == (c_addr_w + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array; no reset needed since the count gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count as is
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sys_seq_ctrl
// Description : Round-robin ALU sequencer. Each START sweeps the enabled
//               channels, issuing one ALU op per channel; the 2*WIDTH-bit
//               results are buffered in sys_res_fifo and streamed out low
//               byte first over a valid/ready TX interface.
//               Optional feature macro: SEQ_TIMEOUT_EN (abandon an ALU op
//               after TIMEOUT WAIT cycles and raise sticky TO_ERR).
// Revision    : 1.0 - initial release
// ============================================================================
module sys_seq_ctrl
    import sys_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ALU_FUN_WD = 4,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    sys_seq_ctrl_if.master bus
);
    localparam int c_ptr_w = $clog2(NUM_CH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    seq_state_t             r_state;
    logic [NUM_CH-1:0]      r_mask;
    logic [c_ptr_w-1:0]     r_ptr;
    logic                   r_alu_en;
    logic [ALU_FUN_WD-1:0]  r_alu_fun;
    logic [c_ptr_w-1:0]     r_alu_sel;
    logic                   r_done;
    logic                   r_byte_sel;

    logic [MAX_CH-1:0]      w_en16;
    logic [MAX_CH-1:0]      w_mask16;
    logic [4:0]             w_first;
    logic [4:0]             w_next;
    logic [ALU_FUN_WD-1:0]  w_fun;
    logic                   w_accept;
    logic                   w_tx_valid;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [2*WIDTH-1:0]     w_head;
    logic [c_cnt_w-1:0]     w_count;

`ifdef SEQ_TIMEOUT_EN
    localparam int                c_to_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);
    logic [c_to_w-1:0]            r_to_cnt;
    logic                         r_to_err;
`endif

    // Widen the live enable mask and the latched mask for the bit search
    always_comb begin
        w_en16                 = '0;
        w_mask16               = '0;
        w_en16[NUM_CH-1:0]     = bus.CH_EN;
        w_mask16[NUM_CH-1:0]   = r_mask;
    end

    assign w_first  = find_next_set(w_en16, 5'd0);
    assign w_next   = find_next_set(w_mask16, 5'(r_ptr) + 5'd1);
    // Function code is read live from CH_FUN at issue time
    assign w_fun    = bus.CH_FUN[r_ptr*ALU_FUN_WD +: ALU_FUN_WD];
    // A result is only taken once the request pulse has gone away
    assign w_accept = (r_state == ST_WAIT) && !r_alu_en && bus.ALU_VLD;

    // Sequencer FSM with registered ALU request, select and DONE outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_mask    <= '0;
            r_ptr     <= '0;
            r_alu_en  <= 1'b0;
            r_alu_fun <= '0;
            r_alu_sel <= '0;
            r_done    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_to_err  <= 1'b0;
`endif
        end else begin
            r_alu_en <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.START) begin
                        r_mask <= bus.CH_EN;
`ifdef SEQ_TIMEOUT_EN
                        r_to_err <= 1'b0;
`endif
                        if (w_first != NO_SET_BIT) begin
                            r_ptr   <= w_first[c_ptr_w-1:0];
                            r_state <= ST_ISSUE;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Hold off while the FIFO has no room so no result is lost
                    if (!w_full) begin
                        r_alu_en  <= 1'b1;
                        r_alu_fun <= w_fun;
                        r_alu_sel <= r_ptr;
                        r_state   <= ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (w_accept) begin
                        r_state <= ST_NEXT;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (!r_alu_en) begin
                        if (r_to_cnt == c_to_last) begin
                            r_to_err <= 1'b1;
                            r_state  <= ST_NEXT;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_NEXT: begin
                    if (w_next == NO_SET_BIT) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ptr   <= w_next[c_ptr_w-1:0];
                        r_state <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sys_res_fifo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_accept),
        .i_data  (bus.ALU_OUT),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_tx_valid = !w_empty;
    assign w_pop      = w_tx_valid && bus.TX_READY && (r_byte_sel == BYTE_HI);

    // Byte serializer: flip halves on every accepted byte, pop after the high one
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_byte_sel <= BYTE_LO;
        end else if (w_tx_valid && bus.TX_READY) begin
            r_byte_sel <= ~r_byte_sel;
        end
    end

    assign bus.TX_VALID   = w_tx_valid;
    assign bus.TX_DATA    = !w_tx_valid ? '0 :
                            (r_byte_sel == BYTE_HI) ? w_head[2*WIDTH-1:WIDTH]
                                                    : w_head[WIDTH-1:0];
    assign bus.FIFO_CNT   = w_count;
    assign bus.ALU_Enable = r_alu_en;
    assign bus.ALU_FUN    = r_alu_fun;
    assign bus.ALU_SEL    = r_alu_sel;
    assign bus.SEQ_BUSY   = (r_state != ST_IDLE);
    assign bus.DONE       = r_done;
`ifdef SEQ_TIMEOUT_EN
    assign bus.TO_ERR     = r_to_err;
`else
    assign bus.TO_ERR     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sys_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_seq_ctrl
// Description : Directed self-checking bench for sys_seq_ctrl. A background
//               ALU responder answers each request one cycle after the
//               request pulse; a monitor collects TX bytes, ALU requests and
//               DONE pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int FWD   = 4;
    localparam int NCH   = 4;
    localparam int FD    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sys_seq_ctrl_if #(.WIDTH(WIDTH), .ALU_FUN_WD(FWD), .NUM_CH(NCH), .FIFO_DEPTH(FD)) bus ();

    sys_seq_ctrl #(
        .WIDTH(WIDTH), .ALU_FUN_WD(FWD), .NUM_CH(NCH), .FIFO_DEPTH(FD), .TIMEOUT(15)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    bit          manual = 1'b0;
    bit          pend = 1'b0;
    int          skip_cnt = 0;
    int          done_cnt = 0;
    int          en_cnt = 0;
    logic [15:0] resp_q[$];
    logic [7:0]  rx_q[$];
    logic [1:0]  sel_log[$];
    logic [3:0]  fun_log[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALU model: answer one cycle after the request pulse unless told to skip
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!manual) begin
                bus.ALU_VLD = 1'b0;
                if (pend) begin
                    bus.ALU_VLD = 1'b1;
                    bus.ALU_OUT = (resp_q.size() > 0) ? resp_q.pop_front() : 16'hDEAD;
                    pend = 1'b0;
                end
                if (bus.ALU_Enable) begin
                    if (skip_cnt > 0) skip_cnt--;
                    else pend = 1'b1;
                end
            end
        end
    end

    // Monitor: sample mid-cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (bus.TX_VALID && bus.TX_READY) rx_q.push_back(bus.TX_DATA);
            if (bus.ALU_Enable) begin
                en_cnt++;
                sel_log.push_back(bus.ALU_SEL);
                fun_log.push_back(bus.ALU_FUN);
            end
            if (bus.DONE) done_cnt++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.START = 1'b0;
        bus.ALU_VLD = 1'b0;
        bus.TX_READY = 1'b0;
        manual = 1'b0;
        skip_cnt = 0;
        tick();
        tick();
        pend = 1'b0;
        rx_q.delete(); resp_q.delete(); sel_log.delete(); fun_log.delete();
        done_cnt = 0;
        en_cnt = 0;
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < max_cyc) begin
            tick();
            n++;
        end
        n_cmp++;
        if (done_cnt == base) begin
            n_err++;
            $display("FAIL %s: DONE not seen within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic wait_en(input int max_cyc, input string name);
        int n;
        n = 0;
        while (bus.ALU_Enable !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.ALU_Enable !== 1'b1) begin
            n_err++;
            $display("FAIL %s: ALU_Enable not seen within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic wait_drain(input int nbytes, input string name);
        int n;
        n = 0;
        while ((rx_q.size() < nbytes || bus.FIFO_CNT != 0) && n < 300) begin
            tick();
            n++;
        end
        n_cmp++;
        if (rx_q.size() != nbytes) begin
            n_err++;
            $display("FAIL %s: received %0d bytes, required %0d", name, rx_q.size(), nbytes);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.START = 1'b1; bus.CH_EN = 4'hF; bus.CH_FUN = 16'hFFFF;
        bus.ALU_VLD = 1'b0; bus.ALU_OUT = 16'h0; bus.TX_READY = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({bus.ALU_Enable, bus.ALU_FUN, bus.ALU_SEL} !== 7'd0) begin
            n_err++; $display("FAIL reset_alu: got %b required 0", {bus.ALU_Enable, bus.ALU_FUN, bus.ALU_SEL});
        end
        n_cmp++;
        if ({bus.TX_VALID, bus.TX_DATA} !== 9'd0) begin
            n_err++; $display("FAIL reset_tx: got %h required 0", {bus.TX_VALID, bus.TX_DATA});
        end
        n_cmp++;
        if ({bus.SEQ_BUSY, bus.DONE, bus.TO_ERR} !== 3'd0) begin
            n_err++; $display("FAIL reset_status: got %b required 000", {bus.SEQ_BUSY, bus.DONE, bus.TO_ERR});
        end
        n_cmp++;
        if (bus.FIFO_CNT !== 3'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d required 0", bus.FIFO_CNT);
        end
        bus.START = 1'b0;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.SEQ_BUSY !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: SEQ_BUSY got %b required 0", bus.SEQ_BUSY);
        end
    endtask

    task automatic test_single_sweep();
        logic [7:0] exp_b [4];
        exp_b = '{8'h34, 8'h12, 8'hCD, 8'hAB};
        do_reset();
        bus.TX_READY = 1'b1;
        bus.CH_EN = 4'b1010;
        bus.CH_FUN = 16'h2000;
        resp_q.push_back(16'h1234);
        resp_q.push_back(16'hABCD);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        n_cmp++;
        if ({bus.SEQ_BUSY, bus.ALU_Enable} !== 2'b10) begin
            n_err++; $display("FAIL single_c1: busy/en got %b required 10", {bus.SEQ_BUSY, bus.ALU_Enable});
        end
        tick();
        n_cmp++;
        if ({bus.ALU_Enable, bus.ALU_SEL, bus.ALU_FUN} !== {1'b1, 2'd1, 4'h0}) begin
            n_err++; $display("FAIL single_c2: en/sel/fun got %h required %h", {bus.ALU_Enable, bus.ALU_SEL, bus.ALU_FUN}, {1'b1, 2'd1, 4'h0});
        end
        tick();
        n_cmp++;
        if ({bus.ALU_Enable, bus.ALU_SEL} !== {1'b0, 2'd1}) begin
            n_err++; $display("FAIL single_c3: en/sel got %b required 001", {bus.ALU_Enable, bus.ALU_SEL});
        end
        wait_done(60, "single_done");
        wait_drain(4, "single_drain");
        repeat (3) tick();
        n_cmp++;
        if (sel_log.size() != 2 || sel_log[0] !== 2'd1 || sel_log[1] !== 2'd3) begin
            n_err++; $display("FAIL single_sel: got %0d ops (%p) required sel 1,3", sel_log.size(), sel_log);
        end
        n_cmp++;
        if (fun_log.size() != 2 || fun_log[0] !== 4'h0 || fun_log[1] !== 4'h2) begin
            n_err++; $display("FAIL single_fun: got %p required 0,2", fun_log);
        end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++;
            if (got !== exp_b[i]) begin
                n_err++; $display("FAIL single_byte%0d: got %h required %h", i, got, exp_b[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || bus.FIFO_CNT !== 3'd0 || bus.SEQ_BUSY !== 1'b0) begin
            n_err++; $display("FAIL single_end: done=%0d cnt=%0d busy=%b required 1/0/0", done_cnt, bus.FIFO_CNT, bus.SEQ_BUSY);
        end
    endtask

    task automatic test_empty_mask();
        do_reset();
        bus.CH_EN = 4'b0000;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        n_cmp++;
        if ({bus.DONE, bus.SEQ_BUSY} !== 2'b10) begin
            n_err++; $display("FAIL empty_c1: done/busy got %b required 10", {bus.DONE, bus.SEQ_BUSY});
        end
        tick();
        n_cmp++;
        if ({bus.DONE, bus.SEQ_BUSY} !== 2'b00) begin
            n_err++; $display("FAIL empty_c2: done/busy got %b required 00", {bus.DONE, bus.SEQ_BUSY});
        end
        repeat (4) tick();
        n_cmp++;
        if (en_cnt != 0) begin
            n_err++; $display("FAIL empty_en: ALU requests got %0d required 0", en_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.TX_READY = 1'b0;
        bus.CH_EN = 4'hF;
        bus.CH_FUN = 16'h3210;
        for (int k = 0; k < 12; k++) resp_q.push_back({4'hC, 4'(k), 4'h5, 4'(k)});
        bus.START = 1'b1; tick(); bus.START = 1'b0;
        wait_done(80, "bp_sweep1");
        bus.START = 1'b1; tick(); bus.START = 1'b0;
        repeat (20) tick();
        n_cmp++;
        if (bus.FIFO_CNT !== 3'd4 || en_cnt != 4 || bus.SEQ_BUSY !== 1'b1) begin
            n_err++; $display("FAIL bp_stall: cnt=%0d reqs=%0d busy=%b required 4/4/1", bus.FIFO_CNT, en_cnt, bus.SEQ_BUSY);
        end
        n_cmp++;
        if ({bus.TX_VALID, bus.TX_DATA} !== {1'b1, 8'h50}) begin
            n_err++; $display("FAIL bp_hold: valid/data got %h required 150", {bus.TX_VALID, bus.TX_DATA});
        end
        bus.TX_READY = 1'b1;
        wait_done(200, "bp_sweep2");
        bus.START = 1'b1; tick(); bus.START = 1'b0;
        wait_done(200, "bp_sweep3");
        wait_drain(24, "bp_drain");
        for (int i = 0; i < 24; i++) begin
            logic [7:0] got;
            logic [7:0] exp;
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            exp = (i % 2 == 0) ? {4'h5, 4'(i / 2)} : {4'hC, 4'(i / 2)};
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL bp_byte%0d: got %h required %h", i, got, exp);
            end
        end
        n_cmp++;
        if (sel_log.size() != 12) begin
            n_err++; $display("FAIL bp_ops: got %0d ALU requests required 12", sel_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++;
                if (sel_log[i] !== 2'(i % 4) || fun_log[i] !== 4'(i % 4)) begin
                    n_err++; $display("FAIL bp_op%0d: sel/fun got %0d/%0d required %0d", i, sel_log[i], fun_log[i], i % 4);
                end
            end
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        manual = 1'b1;
        bus.TX_READY = 1'b0;
        bus.CH_EN = 4'b0011;
        bus.CH_FUN = 16'h0000;
        bus.START = 1'b1; tick(); bus.START = 1'b0;
        wait_en(10, "pp_en0");
        tick();
        bus.ALU_VLD = 1'b1; bus.ALU_OUT = 16'h2211;
        tick();
        bus.ALU_VLD = 1'b0;
        wait_en(10, "pp_en1");
        tick();
        bus.TX_READY = 1'b1;
        tick();
        n_cmp++;
        if ({bus.TX_DATA, bus.FIFO_CNT} !== {8'h22, 3'd1}) begin
            n_err++; $display("FAIL pp_pre: data=%h cnt=%0d required 22/1", bus.TX_DATA, bus.FIFO_CNT);
        end
        bus.ALU_VLD = 1'b1; bus.ALU_OUT = 16'h4433;
        tick();
        bus.ALU_VLD = 1'b0;
        n_cmp++;
        if ({bus.TX_VALID, bus.TX_DATA, bus.FIFO_CNT} !== {1'b1, 8'h33, 3'd1}) begin
            n_err++; $display("FAIL pp_same: valid=%b data=%h cnt=%0d required 1/33/1", bus.TX_VALID, bus.TX_DATA, bus.FIFO_CNT);
        end
        wait_done(20, "pp_done");
        wait_drain(4, "pp_drain");
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++;
            if (got !== exp_b[i]) begin
                n_err++; $display("FAIL pp_byte%0d: got %h required %h", i, got, exp_b[i]);
            end
        end
        manual = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        manual = 1'b1;
        bus.TX_READY = 1'b0;
        bus.CH_EN = 4'b0111;
        bus.START = 1'b1; tick(); bus.START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_en(10, "rm_en");
            tick();
            bus.ALU_VLD = 1'b1; bus.ALU_OUT = 16'h0101 * 16'(i + 1);
            tick();
            bus.ALU_VLD = 1'b0;
        end
        wait_en(10, "rm_en2");
        tick();
        n_cmp++;
        if ({bus.SEQ_BUSY, bus.TX_VALID, bus.FIFO_CNT} !== {1'b1, 1'b1, 3'd2}) begin
            n_err++; $display("FAIL rm_pre: busy=%b valid=%b cnt=%0d required 1/1/2", bus.SEQ_BUSY, bus.TX_VALID, bus.FIFO_CNT);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bus.SEQ_BUSY, bus.TX_VALID, bus.ALU_Enable, bus.FIFO_CNT} !== 6'd0) begin
            n_err++; $display("FAIL rm_post: busy=%b valid=%b en=%b cnt=%0d required all 0", bus.SEQ_BUSY, bus.TX_VALID, bus.ALU_Enable, bus.FIFO_CNT);
        end
        rst = 1'b0;
        manual = 1'b0;
        tick();
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.TX_READY = 1'b1;
        bus.CH_EN = 4'b0011;
        bus.CH_FUN = 16'h0000;
        skip_cnt = 1;
        resp_q.push_back(16'hBEEF);
        bus.START = 1'b1; tick(); bus.START = 1'b0;
        tick();
        n_cmp++;
        if (bus.ALU_Enable !== 1'b1) begin
            n_err++; $display("FAIL to_issue: ALU_Enable got %b required 1", bus.ALU_Enable);
        end
        repeat (15) tick();
        n_cmp++;
        if (bus.TO_ERR !== 1'b0) begin
            n_err++; $display("FAIL to_early: TO_ERR got %b required 0 at cycle 17", bus.TO_ERR);
        end
        tick();
        n_cmp++;
        if (bus.TO_ERR !== 1'b1) begin
            n_err++; $display("FAIL to_set: TO_ERR got %b required 1 at cycle 18", bus.TO_ERR);
        end
        wait_done(40, "to_done");
        wait_drain(2, "to_drain");
        n_cmp++;
        if (en_cnt != 2 || bus.TO_ERR !== 1'b1 || rx_q.size() != 2 || rx_q[0] !== 8'hEF || rx_q[1] !== 8'hBE) begin
            n_err++; $display("FAIL to_result: reqs=%0d to_err=%b bytes=%p required 2/1/EF,BE", en_cnt, bus.TO_ERR, rx_q);
        end
        bus.CH_EN = 4'b0001;
        resp_q.push_back(16'h0001);
        bus.START = 1'b1; tick(); bus.START = 1'b0;
        n_cmp++;
        if (bus.TO_ERR !== 1'b0) begin
            n_err++; $display("FAIL to_clear: TO_ERR got %b required 0", bus.TO_ERR);
        end
        wait_done(40, "to_done2");
    endtask
`endif

    initial begin
        bus.START = 1'b0; bus.CH_EN = '0; bus.CH_FUN = '0;
        bus.ALU_OUT = '0; bus.ALU_VLD = 1'b0; bus.TX_READY = 1'b0;
        test_reset();
        test_single_sweep();
        test_empty_mask();
        test_backpressure();
        test_push_pop();
        test_reset_midop();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
